// File: rtl/true_dp_sram_pkg.sv
// Shared constants and types for the true dual-port SRAM.
// Optional build macro: TRUE_DP_SRAM_WR_FWD_EN (cross-port write forwarding).
package true_dp_sram_pkg;

  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DATA_WIDTH_DEF = 8;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  localparam int DEPTH_DEF = depth_of(ADDR_WIDTH_DEF);

  typedef logic [DATA_WIDTH_DEF-1:0] word_t;

endpackage

// File: rtl/true_dp_sram_if.sv
// Two-port SRAM bus: shared chip select plus independent A/B address, data and enables.
// Optional build macro: TRUE_DP_SRAM_WR_FWD_EN (affects the slave only).
interface true_dp_sram_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  csen_n;
  logic [DATA_WIDTH-1:0] dina;
  logic [ADDR_WIDTH-1:0] addra;
  logic                  wrena_n;
  logic                  rdena_n;
  logic [DATA_WIDTH-1:0] douta;
  logic [DATA_WIDTH-1:0] dinb;
  logic [ADDR_WIDTH-1:0] addrb;
  logic                  wrenb_n;
  logic                  rdenb_n;
  logic [DATA_WIDTH-1:0] doutb;

  modport master (
    output csen_n, dina, addra, wrena_n, rdena_n,
    output dinb, addrb, wrenb_n, rdenb_n,
    input  douta, doutb
  );

  modport slave (
    input  csen_n, dina, addra, wrena_n, rdena_n,
    input  dinb, addrb, wrenb_n, rdenb_n,
    output douta, doutb
  );
endinterface

// File: rtl/true_dp_sram_port.sv
// One read port: registered output with sync active-low clear and a forwarding mux.
// Forwarding is enabled from the top when TRUE_DP_SRAM_WR_FWD_EN is defined.
module true_dp_sram_port #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic                  fwd_hit,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] fwd_data,
  output logic [DATA_WIDTH-1:0] dout
);

  // Output stage: reset wins over any pending read, otherwise hold unless read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (rd_en) begin
      dout <= fwd_hit ? fwd_data : mem_data;
    end
  end

endmodule

// File: rtl/true_dp_sram.sv
// True dual-port SRAM, single clock, read-first per port, port A wins write collisions.
// Define TRUE_DP_SRAM_WR_FWD_EN to forward the other port's same-cycle write to a read.
module true_dp_sram
  import true_dp_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input logic           clk,
  input logic           rst_n,
  true_dp_sram_if.slave bus
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  acc;
  logic                  wr_a, wr_b, rd_a, rd_b;
  logic                  same_addr;
  logic                  hit_a, hit_b;
  logic                  fwd_hit_a, fwd_hit_b;
  logic [DATA_WIDTH-1:0] fwd_data_a;
  logic [DATA_WIDTH-1:0] douta_q, doutb_q;

  assign acc       = !bus.csen_n;
  assign wr_a      = acc && !bus.wrena_n;
  assign wr_b      = acc && !bus.wrenb_n;
  assign rd_a      = acc && !bus.rdena_n;
  assign rd_b      = acc && !bus.rdenb_n;
  assign same_addr = (bus.addra == bus.addrb);

  // A read sees the other port's write; if both write, A's data is what lands.
  assign hit_a      = wr_b && same_addr;
  assign hit_b      = wr_a && same_addr;
  assign fwd_data_a = wr_a ? bus.dina : bus.dinb;

`ifdef TRUE_DP_SRAM_WR_FWD_EN
  assign fwd_hit_a = hit_a;
  assign fwd_hit_b = hit_b;
`else
  assign fwd_hit_a = 1'b0;
  assign fwd_hit_b = 1'b0;
`endif

  // Storage: B written first so A overrides on an address collision.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (wr_b) mem[bus.addrb] <= bus.dinb;
      if (wr_a) mem[bus.addra] <= bus.dina;
    end
  end

  true_dp_sram_port #(.DATA_WIDTH(DATA_WIDTH)) u_port_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (rd_a),
    .fwd_hit  (fwd_hit_a),
    .mem_data (mem[bus.addra]),
    .fwd_data (fwd_data_a),
    .dout     (douta_q)
  );

  true_dp_sram_port #(.DATA_WIDTH(DATA_WIDTH)) u_port_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (rd_b),
    .fwd_hit  (fwd_hit_b),
    .mem_data (mem[bus.addrb]),
    .fwd_data (bus.dina),
    .dout     (doutb_q)
  );

  assign bus.douta = douta_q;
  assign bus.doutb = doutb_q;

endmodule

// File: tb/tb_true_dp_sram.sv
// Self-checking bench for true_dp_sram: directed scenarios plus randomized traffic
// against an array-based reference; honours TRUE_DP_SRAM_WR_FWD_EN.
module tb_true_dp_sram;
  import true_dp_sram_pkg::*;

`ifdef TRUE_DP_SRAM_WR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  true_dp_sram_if #(.ADDR_WIDTH(ADDR_WIDTH_DEF), .DATA_WIDTH(DATA_WIDTH_DEF)) bus ();

  true_dp_sram #(.ADDR_WIDTH(ADDR_WIDTH_DEF), .DATA_WIDTH(DATA_WIDTH_DEF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: word contents plus whether each word has ever been written.
  word_t ref_mem [DEPTH_DEF];
  bit    ref_known [DEPTH_DEF];
  word_t exp_a, exp_b;
  bit    exp_a_known, exp_b_known;

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst_n       = 1'b1;
    bus.csen_n  = 1'b0;
    bus.wrena_n = 1'b1;
    bus.rdena_n = 1'b1;
    bus.wrenb_n = 1'b1;
    bus.rdenb_n = 1'b1;
    bus.addra   = '0;
    bus.addrb   = '0;
    bus.dina    = '0;
    bus.dinb    = '0;
  endtask

  // One clock: apply reference rules at the edge, then compare 1 time unit later.
  task automatic step();
    word_t new_mem [DEPTH_DEF];
    int    a, b;
    bit    wa, wb;
    @(posedge clk);
    a  = int'(bus.addra);
    b  = int'(bus.addrb);
    wa = !bus.wrena_n;
    wb = !bus.wrenb_n;
    if (!rst_n) begin
      exp_a = '0; exp_a_known = 1'b1;
      exp_b = '0; exp_b_known = 1'b1;
    end else if (!bus.csen_n) begin
      new_mem = ref_mem;
      if (wb) new_mem[b] = bus.dinb;
      if (wa) new_mem[a] = bus.dina;
      if (!bus.rdena_n) begin
        if (FWD && wb && b == a) begin
          exp_a = new_mem[a]; exp_a_known = 1'b1;
        end else begin
          exp_a = ref_mem[a]; exp_a_known = ref_known[a];
        end
      end
      if (!bus.rdenb_n) begin
        if (FWD && wa && a == b) begin
          exp_b = new_mem[b]; exp_b_known = 1'b1;
        end else begin
          exp_b = ref_mem[b]; exp_b_known = ref_known[b];
        end
      end
      if (wb) ref_known[b] = 1'b1;
      if (wa) ref_known[a] = 1'b1;
      ref_mem = new_mem;
    end
    #1;
    if (exp_a_known) chk("model_douta", bus.douta, exp_a);
    if (exp_b_known) chk("model_doutb", bus.doutb, exp_b);
  endtask

  initial begin
    for (int i = 0; i < DEPTH_DEF; i++) begin
      ref_mem[i]   = '0;
      ref_known[i] = 1'b0;
    end
    exp_a = '0; exp_b = '0;
    exp_a_known = 1'b0; exp_b_known = 1'b0;

    // Reset with every enable active: outputs clear, nothing written.
    idle();
    rst_n = 1'b0;
    bus.wrena_n = 1'b0; bus.rdena_n = 1'b0;
    step();
    step();
    chk("reset_douta", bus.douta, 8'h00);
    chk("reset_doutb", bus.doutb, 8'h00);

    // Deselected chip: write and read attempts are ignored, output stays 0.
    idle();
    bus.csen_n = 1'b1;
    bus.wrena_n = 1'b0; bus.rdena_n = 1'b0;
    bus.addra = 4'd3; bus.dina = 8'hAA;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("csen_hold_douta", bus.douta, 8'h00);
    end

    // Port A fills the array, then reads it back.
    for (int i = 0; i < DEPTH_DEF; i++) begin
      idle();
      bus.wrena_n = 1'b0; bus.addra = 4'(i); bus.dina = 8'(i + 1);
      step();
    end
    for (int i = 0; i < DEPTH_DEF; i++) begin
      idle();
      bus.rdena_n = 1'b0; bus.addra = 4'(i);
      step();
      chk("porta_rd", bus.douta, 8'(i + 1));
    end

    // Read-enable high: output holds the last word.
    idle();
    bus.addra = 4'd0;
    step();
    chk("hold_douta", bus.douta, 8'h10);

    // Port B overwrites, then both ports read the same address.
    for (int i = 0; i < DEPTH_DEF; i++) begin
      idle();
      bus.wrenb_n = 1'b0; bus.addrb = 4'(i); bus.dinb = 8'(i + 2);
      step();
    end
    for (int i = 0; i < DEPTH_DEF; i++) begin
      idle();
      bus.rdenb_n = 1'b0; bus.addrb = 4'(i);
      bus.rdena_n = 1'b0; bus.addra = 4'(i);
      step();
      chk("portb_rd", bus.doutb, 8'(i + 2));
      chk("cross_rd_a", bus.douta, 8'(i + 2));
    end

    // Same-port read-first: read and write addr 4 together returns old word.
    idle();
    bus.wrena_n = 1'b0; bus.rdena_n = 1'b0; bus.addra = 4'd4; bus.dina = 8'h44;
    step();
    chk("read_first_a", bus.douta, 8'h06);

    // Write collision on addr 5: A wins.
    idle();
    bus.wrena_n = 1'b0; bus.addra = 4'd5; bus.dina = 8'h11;
    bus.wrenb_n = 1'b0; bus.addrb = 4'd5; bus.dinb = 8'h22;
    step();
    idle();
    bus.rdena_n = 1'b0; bus.addra = 4'd5;
    bus.rdenb_n = 1'b0; bus.addrb = 4'd5;
    step();
    chk("collide_a", bus.douta, 8'h11);
    chk("collide_b", bus.doutb, 8'h11);

    // Cross-port write vs read on addr 7 (old word 0x08).
    idle();
    bus.wrena_n = 1'b0; bus.addra = 4'd7; bus.dina = 8'h08;
    step();
    idle();
    bus.wrena_n = 1'b0; bus.addra = 4'd7; bus.dina = 8'h5A;
    bus.rdenb_n = 1'b0; bus.addrb = 4'd7;
    step();
    chk("cross_fwd_b", bus.doutb, FWD ? 8'h5A : 8'h08);
    idle();
    bus.rdenb_n = 1'b0; bus.addrb = 4'd7;
    step();
    chk("after_fwd_b", bus.doutb, 8'h5A);

    // Reset during a read of addr 2 (with a write attempt): output clears, no write.
    idle();
    bus.rdena_n = 1'b0; bus.addra = 4'd5;
    step();
    rst_n = 1'b0;
    bus.rdena_n = 1'b0; bus.wrena_n = 1'b0; bus.addra = 4'd2; bus.dina = 8'hFF;
    step();
    chk("rst_abandon_a", bus.douta, 8'h00);
    idle();
    bus.rdena_n = 1'b0; bus.addra = 4'd2;
    step();
    chk("post_rst_rd_a", bus.douta, 8'h04);

    // Deselected write to addr 3 leaves the stored word unchanged.
    idle();
    bus.csen_n = 1'b1; bus.wrena_n = 1'b0; bus.addra = 4'd3; bus.dina = 8'hAA;
    step();
    idle();
    bus.rdena_n = 1'b0; bus.addra = 4'd3;
    step();
    chk("csen_nowrite", bus.douta, 8'h05);

    // Randomized traffic, narrow address range to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      rst_n       = ($urandom_range(0, 31) != 0);
      bus.csen_n  = ($urandom_range(0, 7) == 0);
      bus.wrena_n = $urandom_range(0, 1) == 1;
      bus.rdena_n = $urandom_range(0, 1) == 1;
      bus.wrenb_n = $urandom_range(0, 1) == 1;
      bus.rdenb_n = $urandom_range(0, 1) == 1;
      bus.addra   = (n < 200) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      bus.addrb   = (n < 200) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      bus.dina    = 8'($urandom);
      bus.dinb    = 8'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
